// File: rtl/colour_timing_pkg.sv
// Shared timing defaults, colour constants and pipeline types for the raster sequencer.
package colour_timing_pkg;

    // Pixel/line counter width; covers both H_TOTAL and V_TOTAL.
    localparam int CNT_W = 9;

    // Horizontal timing defaults (in pixels).
    localparam int H_TOTAL_DEF     = 320;
    localparam int H_ACT_START_DEF = 32;
    localparam int H_ACTIVE_DEF    = 256;
    localparam int H_VIS_END_DEF   = 304;
    localparam int HS_START_DEF    = 308;
    localparam int HS_WIDTH_DEF    = 8;

    // Vertical timing defaults (in lines).
    localparam int V_TOTAL_DEF     = 262;
    localparam int V_ACT_START_DEF = 25;
    localparam int V_ACTIVE_DEF    = 192;
    localparam int V_VIS_END_DEF   = 242;
    localparam int VS_START_DEF    = 246;
    localparam int VS_WIDTH_DEF    = 3;

    // Colour indices.
    localparam logic [3:0] BLANK_COLOUR   = 4'h0;
    localparam logic [3:0] BORDER_DEFAULT = 4'h1;

    typedef logic [CNT_W-1:0] cnt_t;

    // Per-pixel select/sync bundle carried through the pipeline.
    // In stage 1 the sel1 field is the fetch strobe.
    typedef struct packed {
        logic sel1;
        logic sel2;
        logic hsync;
        logic vsync;
    } stage_t;

    localparam int STAGE_W = $bits(stage_t);

    // True when val lies in the half-open window [start, start+len).
    function automatic logic in_range(input cnt_t val, input int start, input int len);
        return (int'(val) >= start) && (int'(val) < start + len);
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Horizontal/vertical raster counters advancing on the pixel enable.
module video_timing_counter
    import colour_timing_pkg::*;
#(
    parameter int H_TOTAL = H_TOTAL_DEF,
    parameter int V_TOTAL = V_TOTAL_DEF
)(
    input  logic clk,
    input  logic srst,
    input  logic pix_en,
    output cnt_t h_count,
    output cnt_t v_count,
    output logic h_wrap,
    output logic v_wrap
);

    localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

    cnt_t h_count_reg;
    cnt_t h_count_next;
    cnt_t v_count_reg;
    cnt_t v_count_next;

    // Next-count logic: line wraps into the next line, last line wraps the frame.
    always_comb begin
        h_count_next = h_count_reg;
        v_count_next = v_count_reg;
        if (pix_en) begin
            if (h_count_reg == H_LAST) begin
                h_count_next = '0;
                if (v_count_reg == V_LAST) begin
                    v_count_next = '0;
                end else begin
                    v_count_next = v_count_reg + cnt_t'(1);
                end
            end else begin
                h_count_next = h_count_reg + cnt_t'(1);
            end
        end
    end

    // Counter state register.
    always_ff @(posedge clk) begin
        if (srst) begin
            h_count_reg <= '0;
            v_count_reg <= '0;
        end else begin
            h_count_reg <= h_count_next;
            v_count_reg <= v_count_next;
        end
    end

    assign h_count = h_count_reg;
    assign v_count = v_count_reg;
    assign h_wrap  = (h_count_reg == H_LAST);
    assign v_wrap  = (v_count_reg == V_LAST);

endmodule

// File: rtl/colour_source_scheduler.sv
// Raster sequencer: region decode, two-stage select pipeline, sync pulses,
// fetch strobe and the frame-synchronous border colour register.
module colour_source_scheduler
    import colour_timing_pkg::*;
#(
    parameter int H_TOTAL     = H_TOTAL_DEF,
    parameter int H_ACT_START = H_ACT_START_DEF,
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_VIS_END   = H_VIS_END_DEF,
    parameter int HS_START    = HS_START_DEF,
    parameter int HS_WIDTH    = HS_WIDTH_DEF,
    parameter int V_TOTAL     = V_TOTAL_DEF,
    parameter int V_ACT_START = V_ACT_START_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int V_VIS_END   = V_VIS_END_DEF,
    parameter int VS_START    = VS_START_DEF,
    parameter int VS_WIDTH    = VS_WIDTH_DEF
)(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PixEn,
    input  logic       CfgWr,
    input  logic [3:0] CfgData,
    output logic       CfgPending,
    output logic [3:0] BorderColour,
    output logic [3:0] Colour3,
    output logic       Sel1,
    output logic       Sel2,
    output logic       HSync,
    output logic       VSync,
    output logic       FetchEn,
    output logic [7:0] PixelX,
    output logic [7:0] PixelY,
    output logic       FrameStart
);

    cnt_t h_count;
    cnt_t v_count;
    logic h_wrap;
    logic v_wrap;

    video_timing_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_counter (
        .clk     (Clk),
        .srst    (Reset),
        .pix_en  (PixEn),
        .h_count (h_count),
        .v_count (v_count),
        .h_wrap  (h_wrap),
        .v_wrap  (v_wrap)
    );

    // ---------------- region decode ----------------
    stage_t     decode_next;
    logic [7:0] pixel_x_next;
    logic [7:0] pixel_y_next;
    logic       act;
    logic       vis;

    // Classify the current counter position; offsets wrap mod 256 so only the
    // low counter bits are needed for the active coordinates.
    always_comb begin
        act = in_range(h_count, H_ACT_START, H_ACTIVE) &&
              in_range(v_count, V_ACT_START, V_ACTIVE);
        vis = (int'(h_count) < H_VIS_END) && (int'(v_count) < V_VIS_END);
        decode_next       = '0;
        decode_next.sel1  = act;
        decode_next.sel2  = vis && !act;
        decode_next.hsync = in_range(h_count, HS_START, HS_WIDTH);
        decode_next.vsync = in_range(v_count, VS_START, VS_WIDTH);
        pixel_x_next = h_count[7:0] - 8'(H_ACT_START);
        pixel_y_next = v_count[7:0] - 8'(V_ACT_START);
    end

    // ---------------- stage 1: fetch strobe and coordinates ----------------
    stage_t     stage1_reg;
    logic [7:0] pixel_x_reg;
    logic [7:0] pixel_y_reg;

    // Stage 1 captures the decode one pixel ahead of the mux selects.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stage1_reg  <= '0;
            pixel_x_reg <= '0;
            pixel_y_reg <= '0;
        end else if (PixEn) begin
            stage1_reg  <= decode_next;
            pixel_x_reg <= pixel_x_next;
            pixel_y_reg <= pixel_y_next;
        end
    end

    // ---------------- stage 2: mux selects and syncs ----------------
    logic [STAGE_W-1:0] stage1_bits;
    logic [STAGE_W-1:0] stage2_bits;
    stage_t             stage2;

    assign stage1_bits = stage1_reg;

    for (genvar gi = 0; gi < STAGE_W; gi++) begin : g_stage2
        logic bit_reg;

        // One stage-2 flop per bundle field, advancing with the pixel enable.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                bit_reg <= 1'b0;
            end else if (PixEn) begin
                bit_reg <= stage1_bits[gi];
            end
        end

        assign stage2_bits[gi] = bit_reg;
    end

    assign stage2 = stage_t'(stage2_bits);

    // ---------------- frame wrap and border colour ----------------
    logic       frame_start;
    logic [3:0] shadow_reg;
    logic       pending_reg;
    logic [3:0] border_reg;

    // Last pixel of the last line being consumed; masked during reset so the
    // pulse never appears while the counters are being cleared.
    assign frame_start = PixEn && h_wrap && v_wrap && !Reset;

    // Writes land in the shadow immediately; the border only changes at the
    // frame wrap, and a write in the wrap cycle itself waits for the next frame.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            shadow_reg  <= BORDER_DEFAULT;
            pending_reg <= 1'b0;
            border_reg  <= BORDER_DEFAULT;
        end else begin
            if (frame_start && pending_reg) begin
                border_reg <= shadow_reg;
            end
            if (CfgWr) begin
                shadow_reg  <= CfgData;
                pending_reg <= 1'b1;
            end else if (frame_start) begin
                pending_reg <= 1'b0;
            end
        end
    end

    // ---------------- outputs ----------------
    assign FetchEn      = stage1_reg.sel1;
    assign PixelX       = pixel_x_reg;
    assign PixelY       = pixel_y_reg;
    assign Sel1         = stage2.sel1;
    assign Sel2         = stage2.sel2;
    assign HSync        = stage2.hsync;
    assign VSync        = stage2.vsync;
    assign FrameStart   = frame_start;
    assign CfgPending   = pending_reg;
    assign BorderColour = border_reg;
    assign Colour3      = BLANK_COLOUR;

endmodule
